// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch stage: FSM state encoding,
// instruction word size and the default reset PC.
package mips_pkg;
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] HALT  = 2'd2;

  localparam int WORD_BYTES = 4;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
endpackage

// File: rtl/pc_fetch_unit_if.sv
// Instruction-memory fetch handshake.
// The fetch unit is the master: it drives req/addr and receives ready/rdata.
interface pc_fetch_unit_if #(
  parameter int WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ready;
  logic [WIDTH-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_ready, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_ready, output imem_rdata);
endinterface

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection.
// Priority is jr, then jump, then taken branch, then the sequential pc+4.
module next_pc_sel
  import mips_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int JFIELD = 28
) (
  input  logic [WIDTH-1:0]  pc,
  input  logic              branch_taken,
  input  logic [15:0]       branch_imm,
  input  logic              jump,
  input  logic [JFIELD-1:0] jump_field,
  input  logic              jr,
  input  logic [WIDTH-1:0]  jr_target,
  output logic [WIDTH-1:0]  pc_plus4,
  output logic [WIDTH-1:0]  next_pc,
  output logic              jr_misaligned
);
  logic [WIDTH-1:0] br_off_s;

  assign pc_plus4      = pc + WIDTH'(WORD_BYTES);
  assign br_off_s      = {{(WIDTH-18){branch_imm[15]}}, branch_imm, 2'b00};
  assign jr_misaligned = (jr_target[1:0] != 2'b00);

  // Priority mux; every arithmetic result wraps at 2^WIDTH.
  always_comb begin
    next_pc = pc_plus4;
    if (jr) begin
      next_pc = {jr_target[WIDTH-1:2], 2'b00};
    end else if (jump) begin
      next_pc = {pc_plus4[WIDTH-1:JFIELD], jump_field};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + br_off_s;
    end else begin
      next_pc = pc_plus4;
    end
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and FETCH/ISSUE/HALT sequencer of the MIPS fetch stage.
// Control inputs from decode are consumed only on a non-stalled ISSUE cycle.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
  parameter int               JFIELD   = 28
) (
  input  logic               clk,
  input  logic               reset,
  pc_fetch_unit_if.master    imem,
  output logic [WIDTH-1:0]   instr,
  output logic               instr_valid,
  output logic [WIDTH-1:0]   pc,
  output logic [WIDTH-1:0]   pc_plus4,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [15:0]        branch_imm,
  input  logic               jump,
  input  logic [JFIELD-1:0]  jump_field,
  input  logic               jr,
  input  logic [WIDTH-1:0]   jr_target,
  input  logic               halt,
  output logic               halted,
  output logic               addr_err
);
  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [WIDTH-1:0] pc_r;
  logic [WIDTH-1:0] instr_r;
  logic [WIDTH-1:0] next_pc_s;
  logic             valid_r;
  logic             halted_r;
  logic             addr_err_r;
  logic             jr_mis_s;
  logic             advance_s;

  next_pc_sel #(
    .WIDTH  (WIDTH),
    .JFIELD (JFIELD)
  ) u_next_pc_sel (
    .pc            (pc_r),
    .branch_taken  (branch_taken),
    .branch_imm    (branch_imm),
    .jump          (jump),
    .jump_field    (jump_field),
    .jr            (jr),
    .jr_target     (jr_target),
    .pc_plus4      (pc_plus4),
    .next_pc       (next_pc_s),
    .jr_misaligned (jr_mis_s)
  );

  assign advance_s = (state_r == ISSUE) && !stall;

  // Next-state logic for the fetch sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FETCH:   state_nxt_s = imem.imem_ready ? ISSUE : FETCH;
      ISSUE: begin
        if (stall) begin
          state_nxt_s = ISSUE;
        end else if (halt) begin
          state_nxt_s = HALT;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      HALT:    state_nxt_s = HALT;
      default: state_nxt_s = FETCH;
    endcase
  end

  // State, PC, latched instruction and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= FETCH;
      pc_r       <= RESET_PC;
      instr_r    <= '0;
      valid_r    <= 1'b0;
      halted_r   <= 1'b0;
      addr_err_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      valid_r  <= (state_nxt_s == ISSUE);
      halted_r <= (state_nxt_s == HALT);
      if ((state_r == FETCH) && imem.imem_ready) begin
        instr_r <= imem.imem_rdata;
      end
      if (advance_s) begin
        pc_r <= next_pc_s;
      end
      // Misaligned jr target: the PC is still forced word-aligned, the flag sticks.
      if (advance_s && jr && jr_mis_s) begin
        addr_err_r <= 1'b1;
      end
    end
  end

  assign imem.imem_req  = (state_r == FETCH) && !reset;
  assign imem.imem_addr = pc_r;
  assign instr          = instr_r;
  assign instr_valid    = valid_r;
  assign pc             = pc_r;
  assign halted         = halted_r;
  assign addr_err       = addr_err_r;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: a table of next-PC vectors plus
// hand-written sequences for reset, wait states, stall, halt and sticky error.
module tb_pc_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [27:0] jump_field;
  logic        jr;
  logic [31:0] jr_target;
  logic        halt;
  logic        halted;
  logic        addr_err;

  int tests_run = 0;
  int tests_failed = 0;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  pc_fetch_unit_if #(.WIDTH(32)) ifc ();

  // Memory model: instruction word is the address scrambled with a key.
  assign ifc.imem_rdata = ifc.imem_addr ^ KEY;

  pc_fetch_unit #(
    .WIDTH    (32),
    .RESET_PC (32'h0000_0000),
    .JFIELD   (28)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .imem         (ifc),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_field   (jump_field),
    .jr           (jr),
    .jr_target    (jr_target),
    .halt         (halt),
    .halted       (halted),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] start_pc;
    logic        br;
    logic [15:0] imm;
    logic        j;
    logic [27:0] jf;
    logic        jrr;
    logic [31:0] jrt;
    logic [31:0] exp_pc;
    logic        exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_ctrl();
    stall = 1'b0; branch_taken = 1'b0; branch_imm = 16'h0000; jump = 1'b0;
    jump_field = 28'h0; jr = 1'b0; jr_target = 32'h0; halt = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // Advance until the DUT is issuing, with a bounded cycle budget.
  task automatic step_to_issue();
    int n;
    n = 0;
    while (!instr_valid && n < 8) begin
      tick();
      n++;
    end
    if (!instr_valid) begin
      tests_run++;
      tests_failed++;
      $display("FAIL issue_timeout: got instr_valid=0 expected 1 within 8 cycles");
    end
  endtask

  task automatic issue(input logic a_br, input logic [15:0] a_imm, input logic a_j,
                       input logic [27:0] a_jf, input logic a_jr, input logic [31:0] a_jrt,
                       input logic a_halt);
    step_to_issue();
    branch_taken = a_br; branch_imm = a_imm; jump = a_j; jump_field = a_jf;
    jr = a_jr; jr_target = a_jrt; halt = a_halt;
    tick();
    clear_ctrl();
    #1;
  endtask

  initial begin
    vecs[0] = '{32'h0000_0020, 1'b1, 16'hFFFE, 1'b0, 28'h0, 1'b0, 32'h0, 32'h0000_001C, 1'b0};
    vecs[1] = '{32'h0000_0020, 1'b1, 16'h0003, 1'b0, 28'h0, 1'b0, 32'h0, 32'h0000_0030, 1'b0};
    vecs[2] = '{32'h4000_0100, 1'b0, 16'h0000, 1'b1, 28'h000_0400, 1'b0, 32'h0, 32'h4000_0400, 1'b0};
    vecs[3] = '{32'h4000_0100, 1'b1, 16'h0003, 1'b1, 28'h000_0400, 1'b1, 32'h0000_0080, 32'h0000_0080, 1'b0};
    vecs[4] = '{32'hFFFF_FFFC, 1'b0, 16'h0000, 1'b0, 28'h0, 1'b0, 32'h0, 32'h0000_0000, 1'b0};
    vecs[5] = '{32'h0000_0100, 1'b0, 16'h0000, 1'b0, 28'h0, 1'b0, 32'h0, 32'h0000_0104, 1'b0};
    vecs[6] = '{32'h0000_1000, 1'b1, 16'h8000, 1'b0, 28'h0, 1'b0, 32'h0, 32'hFFFE_1004, 1'b0};
    vecs[7] = '{32'h4000_0000, 1'b1, 16'h0010, 1'b1, 28'hABC_DEF0, 1'b0, 32'h0, 32'h4ABC_DEF0, 1'b0};
    vecs[8] = '{32'h0000_0000, 1'b0, 16'h0000, 1'b0, 28'h0, 1'b1, 32'h0000_0103, 32'h0000_0100, 1'b1};

    clear_ctrl();
    ifc.imem_ready = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("req_during_reset", {31'h0, ifc.imem_req}, 32'h0);
    do_reset();
    check("reset_pc", pc, 32'h0);
    check("reset_instr", instr, 32'h0);
    check("reset_valid", {31'h0, instr_valid}, 32'h0);
    check("reset_halted", {31'h0, halted}, 32'h0);
    check("reset_addr_err", {31'h0, addr_err}, 32'h0);

    // Sequential fetch with zero wait states: FETCH/ISSUE alternate.
    for (int k = 0; k < 6; k++) begin
      check("seq_req", {31'h0, ifc.imem_req}, (k % 2 == 0) ? 32'h1 : 32'h0);
      check("seq_valid", {31'h0, instr_valid}, (k % 2 == 1) ? 32'h1 : 32'h0);
      if (k % 2 == 0) check("seq_addr", ifc.imem_addr, 32'(4 * (k / 2)));
      else            check("seq_instr", instr, 32'(4 * (k / 2)) ^ KEY);
      tick();
    end

    // Wait states at pc=0x10, then a 2-cycle stall in ISSUE.
    issue(1'b0, 16'h0, 1'b0, 28'h0, 1'b1, 32'h0000_0010, 1'b0);
    ifc.imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("wait_req", {31'h0, ifc.imem_req}, 32'h1);
      check("wait_addr", ifc.imem_addr, 32'h0000_0010);
      check("wait_valid", {31'h0, instr_valid}, 32'h0);
      tick();
    end
    ifc.imem_ready = 1'b1;
    tick();
    check("ready_valid", {31'h0, instr_valid}, 32'h1);
    check("ready_instr", instr, 32'h0000_0010 ^ KEY);
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("stall_valid", {31'h0, instr_valid}, 32'h1);
      check("stall_pc", pc, 32'h0000_0010);
    end
    stall = 1'b0;
    tick();
    check("post_stall_pc", pc, 32'h0000_0014);
    check("post_stall_valid", {31'h0, instr_valid}, 32'h0);

    // Table of next-PC cases; each start PC is loaded with an aligned jr.
    foreach (vecs[i]) begin
      issue(1'b0, 16'h0, 1'b0, 28'h0, 1'b1, vecs[i].start_pc, 1'b0);
      check("vec_start_pc", pc, vecs[i].start_pc);
      issue(vecs[i].br, vecs[i].imm, vecs[i].j, vecs[i].jf, vecs[i].jrr, vecs[i].jrt, 1'b0);
      check("vec_next_pc", pc, vecs[i].exp_pc);
      check("vec_addr_err", {31'h0, addr_err}, {31'h0, vecs[i].exp_err});
    end

    // addr_err stays set across further instructions.
    for (int k = 0; k < 10; k++) issue(1'b0, 16'h0, 1'b0, 28'h0, 1'b0, 32'h0, 1'b0);
    check("sticky_pc", pc, 32'h0000_0128);
    check("sticky_addr_err", {31'h0, addr_err}, 32'h1);

    // Halt: pc still advances, then the unit stays idle.
    issue(1'b0, 16'h0, 1'b0, 28'h0, 1'b0, 32'h0, 1'b1);
    check("halt_pc", pc, 32'h0000_012C);
    for (int k = 0; k < 5; k++) begin
      check("halted", {31'h0, halted}, 32'h1);
      check("halt_req", {31'h0, ifc.imem_req}, 32'h0);
      check("halt_valid", {31'h0, instr_valid}, 32'h0);
      tick();
    end
    check("halt_pc_held", pc, 32'h0000_012C);

    // Reset landing on a FETCH cycle with ready high discards the fetch.
    do_reset();
    issue(1'b0, 16'h0, 1'b0, 28'h0, 1'b1, 32'h0000_0040, 1'b0);
    check("pre_reset_fetch_addr", ifc.imem_addr, 32'h0000_0040);
    reset = 1'b1;
    #1;
    check("midfetch_req", {31'h0, ifc.imem_req}, 32'h0);
    tick();
    reset = 1'b0;
    #1;
    check("midfetch_pc", pc, 32'h0);
    check("midfetch_instr", instr, 32'h0);
    check("midfetch_valid", {31'h0, instr_valid}, 32'h0);
    check("midfetch_addr_err", {31'h0, addr_err}, 32'h0);
    check("midfetch_halted", {31'h0, halted}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Program-counter and instruction-fetch stage of the MIPS CPU.
- Holds the PC and fetches instructions from instruction memory over a req/ready handshake.
- Presents each fetched instruction to decode for one issue cycle.
- Computes next PC from the decode/ALU outcome: sequential, branch, jump (pre-shifted 28-bit field), or jr.

Parameters:
- WIDTH, 32, datapath/PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- JFIELD, 28, width of the pre-shifted jump target field (instr[25:0] with 2'b00 appended).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  WIDTH  fetch address; always equals pc.
- imem_ready  in  1  memory has imem_rdata valid this cycle.
- imem_rdata  in  WIDTH  fetched instruction word.
- instr  out  WIDTH  latched instruction to decode.
- instr_valid  out  1  high for each ISSUE cycle.
- pc  out  WIDTH  current PC.
- pc_plus4  out  WIDTH  pc + 4, combinational.
- stall  in  1  hold in ISSUE; PC not updated.
- branch_taken  in  1  conditional branch resolved taken.
- branch_imm  in  16  instr[15:0] branch offset.
- jump  in  1  j/jal.
- jump_field  in  JFIELD  pre-shifted jump target.
- jr  in  1  jump-register.
- jr_target  in  WIDTH  rs register value.
- halt  in  1  halt instruction decoded.
- halted  out  1  unit halted.
- addr_err  out  1  sticky misaligned jr target flag.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high; reset has priority over every other input.
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, halted=0, addr_err=0, state=FETCH. imem_req is forced 0 during any cycle in which reset=1.

FSM, state FETCH:
- imem_req=1 and imem_addr=pc.
- If imem_ready=1: instr<=imem_rdata, go to ISSUE.
- Otherwise stay in FETCH, holding the request and address stable.

FSM, state ISSUE:
- instr_valid=1 and imem_req=0.
- If stall=1: stay in ISSUE; pc and instr unchanged.
- Otherwise pc<=next_pc. If halt=1 go to HALT (pc still updated), else go to FETCH.

FSM, state HALT:
- halted=1, imem_req=0, instr_valid=0. Exit only via reset.

Next-PC selection (priority jr > jump > branch_taken > sequential):
- jr: {jr_target[WIDTH-1:2], 2'b00}. If jr_target[1:0]!=0, set addr_err (sticky until reset).
- jump: {pc_plus4[WIDTH-1:JFIELD], jump_field}.
- branch: pc_plus4 + (sign-extend(branch_imm) << 2), modulo 2^WIDTH (wraps, no flag).
- sequential: pc_plus4, wraps at 2^WIDTH.

Timing and boundary rules:
- Control inputs are sampled only in non-stalled ISSUE cycles and ignored in all other states.
- Minimum 2 cycles per instruction, when imem_ready=1 in the first FETCH cycle.
- imem_rdata is sampled only on a FETCH cycle with imem_ready=1; imem_ready in other states is ignored.
- Reset during FETCH, ISSUE or HALT takes effect at the next edge, discarding any in-flight fetch.

Decomposition:
- Shared package mips_pkg:
  - state encoding: FETCH=2'd0, ISSUE=2'd1, HALT=2'd2;
  - WORD_BYTES=4;
  - the RESET_PC default.
- One natural sub-module, next_pc_sel: purely combinational priority mux and adders. The FSM and PC register stay in the top level.

Test Plan:
- Reset/sequential: reset 2 cycles, imem_ready tied 1 → imem_addr 0x0, 0x4, 0x8 on successive FETCH cycles; instr_valid pulses every 2nd cycle.
- Wait states: imem_ready low 3 cycles at pc=0x10 → imem_req and imem_addr=0x10 held stable; instr_valid rises the cycle after ready. Stall 2 cycles in ISSUE → pc stays 0x10, instr_valid high 3 cycles.
- Branch:
  - pc=0x20, branch_taken, imm=16'hFFFE → next pc 0x1C;
  - imm=16'h0003 → 0x30.
- Jump and priority:
  - pc=0x4000_0100, jump, jump_field=28'h000_0400 → 0x4000_0400;
  - jump+branch_taken+jr(0x80) together → 0x80.
- jr misaligned: jr_target=0x0000_0103 → pc=0x100, addr_err=1, still set 10 instructions later.
- Halt and reset-mid-fetch:
  - halt in ISSUE → halted=1, imem_req=0 indefinitely;
  - reset asserted mid-FETCH with imem_ready=1 → instr stays 0, pc=RESET_PC.
- Wrap: pc=0xFFFF_FFFC sequential → pc=0x0000_0000.
